// File: rtl/div_ctrl_pkg.sv
// Shared types and constants for the divide-ratio controller.
`default_nettype none

package div_ctrl_pkg;

    localparam int DIV_W_DEFAULT = 4;
    localparam int DIV_MIN       = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2,
        STOP = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/div_period_cnt.sv
// Period counter with clk_out/tick decode for a ratio of at least 2.
`default_nettype none

module div_period_cnt
    import div_ctrl_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEFAULT
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clear,
    input  logic             advance,
    input  logic [DIV_W-1:0] ratio,
    output logic [DIV_W-1:0] cnt,
    output logic             last,
    output logic             clk_out,
    output logic             tick
);

    logic [DIV_W-1:0] half;

    assign last = (cnt == ratio - DIV_W'(1));
    assign half = ratio >> 1;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (advance) begin
            cnt <= last ? '0 : cnt + DIV_W'(1);
        end
    end

    // cnt is held at zero while idle, so this decode is already low there.
    assign clk_out = (cnt != '0) && (cnt <= half);
    assign tick    = (cnt == DIV_W'(1));

endmodule

`default_nettype wire

// File: rtl/div_ratio_ctrl.sv
// Programmable clock divider: run/stop FSM with glitch-free ratio changes at period boundaries.
`default_nettype none

module div_ratio_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int DIV_W     = DIV_W_DEFAULT,
    parameter int DIV_RESET = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             clk_out,
    output logic             tick,
    output logic             busy,
    output logic [DIV_W-1:0] cur_div
);

    state_t           state, state_nxt;
    logic [DIV_W-1:0] pend_div, pend_nxt, cur_nxt;
    logic [DIV_W-1:0] cnt;
    logic             last, clear, advance;
    logic             hs, legal, cfg_ok, cfg_bad;

    assign cfg_ready = (state == IDLE) || (state == RUN);
    assign busy      = (state != IDLE);
    assign hs        = cfg_valid && cfg_ready;
    assign legal     = (cfg_div >= DIV_W'(DIV_MIN));
    assign cfg_ok    = hs && legal;
    assign cfg_bad   = hs && !legal;

    always_comb begin
        state_nxt = state;
        cur_nxt   = cur_div;
        pend_nxt  = pend_div;
        clear     = 1'b0;
        advance   = 1'b0;
        case (state)
            IDLE: begin
                clear = 1'b1;
                if (cfg_ok) cur_nxt = cfg_div;
                if (en && !cfg_bad) state_nxt = RUN;
            end
            RUN: begin
                advance = 1'b1;
                if (cfg_ok) begin
                    pend_nxt  = cfg_div;
                    state_nxt = PEND;
                end else if (!cfg_bad && !en) begin
                    state_nxt = STOP;
                end
            end
            PEND: begin
                advance = 1'b1;
                // New ratio takes effect exactly as the counter wraps.
                if (last) begin
                    cur_nxt   = pend_div;
                    state_nxt = en ? RUN : IDLE;
                end
            end
            STOP: begin
                advance = 1'b1;
                if (en) begin
                    state_nxt = RUN;
                end else if (last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= IDLE;
            cur_div  <= DIV_W'(DIV_RESET);
            pend_div <= DIV_W'(DIV_RESET);
            cfg_err  <= 1'b0;
        end else begin
            state    <= state_nxt;
            cur_div  <= cur_nxt;
            pend_div <= pend_nxt;
            cfg_err  <= cfg_bad;
        end
    end

    div_period_cnt #(
        .DIV_W (DIV_W)
    ) u_cnt (
        .clk     (clk),
        .resetn  (resetn),
        .clear   (clear),
        .advance (advance),
        .ratio   (cur_div),
        .cnt     (cnt),
        .last    (last),
        .clk_out (clk_out),
        .tick    (tick)
    );

endmodule

`default_nettype wire

// File: tb/tb_div_ratio_ctrl.sv
// Self-checking bench: directed scenarios plus random stimulus against a behavioural model.
`default_nettype none

module tb_div_ratio_ctrl;

    logic       clk = 1'b0;
    logic       resetn, en, cfg_valid;
    logic [3:0] cfg_div;
    logic       cfg_ready, cfg_err, clk_out, tick, busy;
    logic [3:0] cur_div;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    div_ratio_ctrl #(.DIV_W(4), .DIV_RESET(2)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .clk_out   (clk_out),
        .tick      (tick),
        .busy      (busy),
        .cur_div   (cur_div)
    );

    // Behavioural model: position within the current period plus mode flags.
    bit m_active, m_stopping, m_pending, m_err;
    int m_pos, m_ratio, m_next_ratio;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit m_ready();
        return !(m_pending || m_stopping);
    endfunction

    task automatic compare();
        bit high;
        high = m_active && (m_pos >= 1) && (m_pos <= m_ratio / 2);
        check("clk_out",   32'(clk_out),   32'(high));
        check("tick",      32'(tick),      32'(m_active && m_pos == 1));
        check("busy",      32'(busy),      32'(m_active));
        check("cfg_ready", 32'(cfg_ready), 32'(m_ready()));
        check("cfg_err",   32'(cfg_err),   32'(m_err));
        check("cur_div",   32'(cur_div),   32'(m_ratio));
    endtask

    task automatic model_step(input bit e, input bit v, input int d, input bit r);
        bit hs, good, bad, at_end;
        if (!r) begin
            m_active = 0; m_stopping = 0; m_pending = 0; m_err = 0;
            m_pos = 0; m_ratio = 2; m_next_ratio = 2;
            return;
        end
        hs     = v && m_ready();
        good   = hs && d >= 2;
        bad    = hs && d < 2;
        at_end = m_active && (m_pos == m_ratio - 1);
        if (!m_active) begin
            if (good) m_ratio = d;
            if (e && !bad) m_active = 1;
            m_pos = 0;
        end else begin
            m_pos = (m_pos + 1) % m_ratio;
            if (m_pending) begin
                if (at_end) begin
                    m_ratio = m_next_ratio;
                    m_pending = 0;
                    m_active = e;
                end
            end else if (m_stopping) begin
                if (e) m_stopping = 0;
                else if (at_end) begin
                    m_stopping = 0;
                    m_active = 0;
                end
            end else if (good) begin
                m_pending = 1;
                m_next_ratio = d;
            end else if (!bad && !e) begin
                m_stopping = 1;
            end
        end
        m_err = bad;
    endtask

    task automatic cyc(input bit e, input bit v, input int d, input bit r);
        @(negedge clk);
        compare();
        en = e; cfg_valid = v; cfg_div = 4'(d); resetn = r;
        @(posedge clk);
        model_step(e, v, d, r);
    endtask

    task automatic run_until_pos(input int p, input bit e);
        for (int k = 0; k < 20 && m_pos != p; k++) cyc(e, 0, 0, 1);
        check("pos_reached", 32'(m_pos), 32'(p));
    endtask

    initial begin
        resetn = 0; en = 0; cfg_valid = 0; cfg_div = 0;
        m_active = 0; m_stopping = 0; m_pending = 0; m_err = 0;
        m_pos = 0; m_ratio = 2; m_next_ratio = 2;
        @(posedge clk);
        model_step(0, 0, 0, 0);
        repeat (2) cyc(0, 1, 9, 0);

        // Default ratio 2 free-running, then stop.
        repeat (8) cyc(1, 0, 0, 1);
        repeat (4) cyc(0, 0, 0, 1);

        // Ratio 6 loaded while idle.
        cyc(0, 1, 6, 1);
        repeat (14) cyc(1, 0, 0, 1);

        // Ratio 4 to 5 change mid-period.
        repeat (8) cyc(0, 0, 0, 1);
        cyc(1, 1, 4, 1);
        repeat (5) cyc(1, 0, 0, 1);
        run_until_pos(1, 1);
        cyc(1, 1, 5, 1);
        repeat (14) cyc(1, 0, 0, 1);

        // Illegal ratio rejected while running.
        cyc(1, 1, 1, 1);
        repeat (4) cyc(1, 0, 0, 1);
        cyc(1, 1, 0, 1);
        repeat (3) cyc(1, 0, 0, 1);

        // Ratio 6, en dropped at cnt 2, then re-enabled during a later stop.
        cyc(1, 1, 6, 1);
        repeat (10) cyc(1, 0, 0, 1);
        run_until_pos(2, 1);
        cyc(0, 0, 0, 1);
        repeat (8) cyc(0, 0, 0, 1);
        repeat (3) cyc(1, 0, 0, 1);
        cyc(0, 0, 0, 1);
        cyc(1, 0, 0, 1);
        repeat (6) cyc(1, 0, 0, 1);

        // Reset while a ratio 8 change is pending on ratio 4.
        cyc(1, 1, 4, 1);
        repeat (8) cyc(1, 0, 0, 1);
        cyc(1, 1, 8, 1);
        cyc(1, 0, 0, 0);
        repeat (6) cyc(1, 0, 0, 1);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            bit r, e, v;
            int d;
            r = ($urandom_range(0, 199) != 0);
            e = ($urandom_range(0, 9) < 8);
            v = ($urandom_range(0, 5) == 0);
            d = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1) : $urandom_range(0, 15);
            cyc(e, v, d, r);
        end
        @(negedge clk);
        compare();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/div_ratio_ctrl.md
DIV_RATIO_CTRL -- requirements
Module: div_ratio_ctrl

Interface
REQ-001 SHALL have parameter DIV_W, default 4, meaning the width of the divide-ratio field.
REQ-002 SHALL have parameter DIV_RESET, default 2, meaning the ratio loaded at reset.
REQ-003 SHALL have port clk, input, 1 bit: clock, rising edge.
REQ-004 SHALL have port resetn, input, 1 bit: reset, synchronous, active-low.
REQ-005 SHALL have port en, input, 1 bit: run request.
REQ-006 SHALL have port cfg_valid, input, 1 bit: new ratio offered.
REQ-007 SHALL have port cfg_div, input, DIV_W bits: requested divide ratio N.
REQ-008 SHALL have port cfg_ready, output, 1 bit: ratio can be accepted this cycle.
REQ-009 SHALL have port cfg_err, output, 1 bit: one-cycle pulse when an illegal ratio is rejected.
REQ-010 SHALL have port clk_out, output, 1 bit: divided waveform.
REQ-011 SHALL have port tick, output, 1 bit: one-cycle pulse on the first high cycle of clk_out.
REQ-012 SHALL have port busy, output, 1 bit: state is not IDLE.
REQ-013 SHALL have port cur_div, output, DIV_W bits: active ratio.

Function
REQ-014 SHALL implement the FSM states IDLE, RUN, PEND and STOP.
REQ-015 SHALL treat cfg_div values 2..2^DIV_W-1 as legal; on a handshake with a value of 0 or 1, SHALL assert cfg_err for one cycle, discard the value, and leave the state and cur_div unchanged.
REQ-016 SHALL complete a config handshake when cfg_valid and cfg_ready are both high; cfg_ready SHALL be 1 in IDLE and RUN and 0 in PEND and STOP.
REQ-017 In RUN, PEND and STOP, counter cnt SHALL step 0..cur_div-1 and wrap to 0, one step per cycle.
REQ-018 SHALL drive clk_out=1 iff state is not IDLE and 1 <= cnt <= floor(cur_div/2); otherwise clk_out=0.
REQ-019 SHALL drive tick=1 iff state is not IDLE and cnt==1.
REQ-020 The period boundary SHALL be the cycle in which cnt==cur_div-1.
REQ-021 IDLE: cnt SHALL be held at 0; a legal config SHALL load cur_div in the next cycle; en=1 SHALL enter RUN with cnt=0 in the next cycle.
REQ-022 RUN: a legal config SHALL be stored in pend_div and the FSM SHALL enter PEND; en=0 without a config SHALL enter STOP.
REQ-023 RUN with a legal config and en=0 in the same cycle: the config SHALL take priority and the FSM SHALL enter PEND.
REQ-024 PEND: at the boundary, cur_div SHALL be loaded from pend_div and cnt SHALL go to 0; the FSM SHALL then go to RUN if en=1, else IDLE.
REQ-025 STOP: en=1 SHALL return the FSM to RUN with no disturbance to cnt; at the boundary with en=0, the FSM SHALL go to IDLE with cnt=0.
REQ-026 A period already in progress SHALL never be truncated or stretched by a config change or by en falling.
REQ-027 busy SHALL be 1 iff state is not IDLE.

Reset
REQ-028 While resetn=0 at a clk edge: state=IDLE, cnt=0, cur_div=DIV_RESET, pend_div=DIV_RESET.
REQ-029 During reset, outputs SHALL be clk_out=0, tick=0, busy=0, cfg_err=0, cfg_ready=1.
REQ-030 Reset SHALL abort any state, including PEND, immediately, and any pending ratio SHALL be lost.

Structure
REQ-031 Package div_ctrl_pkg SHALL hold the state enum, DIV_MIN=2, and the default DIV_W.
REQ-032 The counter and clk_out/tick decode SHALL be the sub-module div_period_cnt, with inputs clear, advance and ratio, and outputs cnt, last, clk_out and tick.
REQ-033 The top SHALL contain the FSM, the config handshake and the pend_div register.

Verification
REQ-034 Reset, then en=1 with no config: clk_out=0,1,0,1...; tick every 2nd cycle; busy=1.
REQ-035 In IDLE, cfg_div=6 handshake, then en=1: clk_out=0,1,1,1,0,0 repeating; cur_div=6.
REQ-036 RUN with N=4, cfg_div=5 accepted at cnt=1: cfg_ready=0 until the boundary; the current period completes 4 cycles; the next periods are 0,1,1,0,0; cur_div=5.
REQ-037 cfg_div=1 offered in RUN: one-cycle cfg_err pulse; cur_div and the waveform are unchanged; cfg_ready stays 1.
REQ-038 N=6, en dropped at cnt=2: clk_out finishes 1,0,0 from cnt=3, then IDLE and busy=0; re-assert en during STOP: no gap in the waveform.
REQ-039 resetn=0 during PEND (N=4, pending 8): next cycle busy=0, cur_div=2; after en=1, period 2.
